// File: rtl/sb_tx_msg_arbiter.sv
// -----------------------------------------------------------------------------
// sb_tx_msg_arbiter
//
// Shares the single sideband TX message path among NUM_REQ requesters (LTSM
// training FSM, adapter/RDI link management, test-mode control).
//
// While idle, the arbiter picks one pending requester round-robin and latches
// that requester's message fields. It then issues a one-cycle strobe towards the
// SB TX path and follows the TX busy handshake. When the message has gone out it
// pulses o_done to the granted requester; if TX never goes busy it pulses o_err
// instead. Either way the round-robin pointer then moves past that requester.
//
// Parameters
//   NUM_REQ         number of requesters (2..8)
//   ACCEPT_TIMEOUT  cycles to wait for i_busy to rise after issue (>= 2)
//
// Ports
//   i_clk          sideband clock
//   i_rst          synchronous active-high reset
//   i_flush        LTSM-in-reset abort; returns to IDLE without done/err pulses
//   i_req          per-requester request level
//   i_msg_no       message number, requester k at [4k+3:4k]
//   i_msg_info     message info, requester k at [3k+2:3k]
//   i_data_bus     message data, requester k at [16k+15:16k]
//   i_data_valid   per-requester "message carries data" flag
//   i_busy         SB TX path busy
//   o_msg_valid    one-cycle message strobe to SB TX
//   o_msg_no       captured message number (0 after reset/flush)
//   o_msg_info     captured message info (0 after reset/flush)
//   o_data_bus     captured data (0 after reset/flush)
//   o_data_valid   captured data-valid, only alongside o_msg_valid
//   o_grant        one-hot grant, from ISSUE through the last WAIT_DONE cycle
//   o_done         one-cycle pulse: message sent
//   o_err          one-cycle pulse: accept timeout
//   o_arb_busy     high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module sb_tx_msg_arbiter #(
  parameter int NUM_REQ        = 3,
  parameter int ACCEPT_TIMEOUT = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_flush,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [4*NUM_REQ-1:0]    i_msg_no,
  input  logic [3*NUM_REQ-1:0]    i_msg_info,
  input  logic [16*NUM_REQ-1:0]   i_data_bus,
  input  logic [NUM_REQ-1:0]      i_data_valid,
  input  logic                    i_busy,
  output logic                    o_msg_valid,
  output logic [3:0]              o_msg_no,
  output logic [2:0]              o_msg_info,
  output logic [15:0]             o_data_bus,
  output logic                    o_data_valid,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_done,
  output logic [NUM_REQ-1:0]      o_err,
  output logic                    o_arb_busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ACCEPT_TIMEOUT > 1) ? $clog2(ACCEPT_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t             state_reg, state_next;
  logic [PTR_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [PTR_W-1:0]   grant_idx_reg;
  logic [PTR_W-1:0]   ptr_after_grant;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [NUM_REQ-1:0] done_reg, done_next;
  logic [NUM_REQ-1:0] err_reg, err_next;
  logic [NUM_REQ-1:0] grant_onehot;

  // Held message fields and a flag that says whether they may be shown.
  // A flush hides them without disturbing the stored values.
  logic [3:0]         msg_no_reg;
  logic [2:0]         msg_info_reg;
  logic [15:0]        data_bus_reg;
  logic               data_valid_reg;
  logic               fields_vis_reg;

  // Arbitration result
  logic               sel_found;
  logic [PTR_W-1:0]   sel_idx;
  logic               capture;
  int                 cand;

  // Per-requester field views, so capture is a plain array index
  logic [3:0]         req_msg_no   [NUM_REQ];
  logic [2:0]         req_msg_info [NUM_REQ];
  logic [15:0]        req_data_bus [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign req_msg_no[gi]   = i_msg_no[4*gi +: 4];
      assign req_msg_info[gi] = i_msg_info[3*gi +: 3];
      assign req_data_bus[gi] = i_data_bus[16*gi +: 16];
      assign grant_onehot[gi] = (grant_idx_reg == PTR_W'(gi));
    end
  endgenerate

  // Round-robin pick: the first set request at or above rr_ptr, wrapping at
  // NUM_REQ-1. The loop walks offsets from largest to smallest so that the
  // smallest offset (the highest priority) is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = int'(rr_ptr_reg) + i;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      if (i_req[cand[PTR_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // Priority moves to the requester after the one just served.
  assign ptr_after_grant = (grant_idx_reg == PTR_LAST) ? '0 : grant_idx_reg + 1'b1;

  // Next-state logic
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    rr_ptr_next = rr_ptr_reg;
    done_next   = '0;
    err_next    = '0;
    capture     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (sel_found) begin
          capture    = 1'b1;
          state_next = ISSUE;
        end
      end

      ISSUE: begin
        // i_busy during ISSUE belongs to earlier traffic and is not looked at.
        cnt_next   = '0;
        state_next = WAIT_BUSY;
      end

      WAIT_BUSY: begin
        if (i_busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg == CNT_LAST) begin
          err_next    = grant_onehot;
          rr_ptr_next = ptr_after_grant;
          state_next  = IDLE;
        end else begin
          // Leaving at CNT_LAST caps the count there, so it never wraps.
          cnt_next = cnt_reg + 1'b1;
        end
      end

      WAIT_DONE: begin
        if (!i_busy) begin
          done_next   = grant_onehot;
          rr_ptr_next = ptr_after_grant;
          state_next  = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Flush wins over any handshake event in the same cycle. It produces no
    // completion pulse and leaves the pointer alone.
    if (i_flush) begin
      state_next  = IDLE;
      cnt_next    = '0;
      rr_ptr_next = rr_ptr_reg;
      done_next   = '0;
      err_next    = '0;
      capture     = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      rr_ptr_reg     <= '0;
      grant_idx_reg  <= '0;
      done_reg       <= '0;
      err_reg        <= '0;
      msg_no_reg     <= '0;
      msg_info_reg   <= '0;
      data_bus_reg   <= '0;
      data_valid_reg <= 1'b0;
      fields_vis_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      rr_ptr_reg <= rr_ptr_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      if (capture) begin
        grant_idx_reg  <= sel_idx;
        msg_no_reg     <= req_msg_no[sel_idx];
        msg_info_reg   <= req_msg_info[sel_idx];
        data_bus_reg   <= req_data_bus[sel_idx];
        data_valid_reg <= i_data_valid[sel_idx];
        fields_vis_reg <= 1'b1;
      end else if (i_flush) begin
        fields_vis_reg <= 1'b0;
      end
    end
  end

  // All outputs decode registered state only.
  assign o_msg_valid  = (state_reg == ISSUE);
  assign o_data_valid = (state_reg == ISSUE) && data_valid_reg;
  assign o_grant      = (state_reg != IDLE) ? grant_onehot : '0;
  assign o_arb_busy   = (state_reg != IDLE);
  assign o_done       = done_reg;
  assign o_err        = err_reg;
  assign o_msg_no     = fields_vis_reg ? msg_no_reg   : 4'h0;
  assign o_msg_info   = fields_vis_reg ? msg_info_reg : 3'h0;
  assign o_data_bus   = fields_vis_reg ? data_bus_reg : 16'h0;

endmodule

// File: tb/tb_sb_tx_msg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sb_tx_msg_arbiter
//
// Directed bench for sb_tx_msg_arbiter (NUM_REQ=3, ACCEPT_TIMEOUT=64).
//
// A transaction-level model follows each message through these phases:
//   - issued:        age 0 is the strobe cycle
//   - awaiting busy: waiting for i_busy to rise
//   - awaiting idle: waiting for i_busy to fall
// A negedge process compares every DUT output with the model. The directed
// sequence also checks hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_sb_tx_msg_arbiter;

  localparam int N   = 3;
  localparam int ATO = 64;

  logic          clk;
  logic          i_rst, i_flush, i_busy;
  logic [N-1:0]  i_req, i_data_valid;
  logic [4*N-1:0]  i_msg_no;
  logic [3*N-1:0]  i_msg_info;
  logic [16*N-1:0] i_data_bus;
  logic          o_msg_valid, o_data_valid, o_arb_busy;
  logic [3:0]    o_msg_no;
  logic [2:0]    o_msg_info;
  logic [15:0]   o_data_bus;
  logic [N-1:0]  o_grant, o_done, o_err;

  sb_tx_msg_arbiter #(.NUM_REQ(N), .ACCEPT_TIMEOUT(ATO)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_flush(i_flush), .i_req(i_req),
    .i_msg_no(i_msg_no), .i_msg_info(i_msg_info), .i_data_bus(i_data_bus),
    .i_data_valid(i_data_valid), .i_busy(i_busy),
    .o_msg_valid(o_msg_valid), .o_msg_no(o_msg_no), .o_msg_info(o_msg_info),
    .o_data_bus(o_data_bus), .o_data_valid(o_data_valid), .o_grant(o_grant),
    .o_done(o_done), .o_err(o_err), .o_arb_busy(o_arb_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- model
  int         m_ptr, m_g, m_age;
  logic       m_active, m_seen, m_show, m_dv;
  logic [3:0] m_no;
  logic [2:0] m_info;
  logic [15:0] m_data;
  logic [N-1:0] m_done, m_err;
  int         m_pick;

  function automatic int pick(input logic [N-1:0] req, input int ptr);
    for (int off = 0; off < N; off++) begin
      if (req[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  assign m_pick = pick(i_req, m_ptr);

  always @(posedge clk) begin
    if (i_rst) begin
      m_active <= 1'b0; m_seen <= 1'b0; m_show <= 1'b0; m_dv <= 1'b0;
      m_ptr <= 0; m_g <= 0; m_age <= 0;
      m_no <= '0; m_info <= '0; m_data <= '0;
      m_done <= '0; m_err <= '0;
    end else if (i_flush) begin
      m_active <= 1'b0; m_show <= 1'b0; m_done <= '0; m_err <= '0;
    end else begin
      m_done <= '0;
      m_err  <= '0;
      if (!m_active) begin
        if (m_pick >= 0) begin
          m_active <= 1'b1; m_seen <= 1'b0; m_age <= 0; m_g <= m_pick; m_show <= 1'b1;
          m_no   <= i_msg_no[m_pick*4 +: 4];
          m_info <= i_msg_info[m_pick*3 +: 3];
          m_data <= i_data_bus[m_pick*16 +: 16];
          m_dv   <= i_data_valid[m_pick];
        end
      end else if (m_age == 0) begin
        m_age <= 1;                       // strobe cycle: busy ignored
      end else if (!m_seen) begin
        if (i_busy) m_seen <= 1'b1;
        else if (m_age == ATO) begin      // ATO cycles of waiting, no busy seen
          m_err <= N'(1 << m_g); m_active <= 1'b0; m_ptr <= (m_g + 1) % N;
        end else m_age <= m_age + 1;
      end else if (!i_busy) begin
        m_done <= N'(1 << m_g); m_active <= 1'b0; m_ptr <= (m_g + 1) % N;
      end
    end
  end

  // ---------------------------------------------------------------- compare
  always @(negedge clk) begin
    if (cmp_en) begin
      logic ev;
      logic [N-1:0] eg;
      ev = m_active && (m_age == 0);
      eg = m_active ? N'(1 << m_g) : '0;
      chk("msg_valid",  32'(o_msg_valid),  32'(ev));
      chk("data_valid", 32'(o_data_valid), 32'(ev && m_dv));
      chk("grant",      32'(o_grant),      32'(eg));
      chk("arb_busy",   32'(o_arb_busy),   32'(m_active));
      chk("done",       32'(o_done),       32'(m_done));
      chk("err",        32'(o_err),        32'(m_err));
      chk("msg_no",     32'(o_msg_no),     m_show ? 32'(m_no)   : 32'h0);
      chk("msg_info",   32'(o_msg_info),   m_show ? 32'(m_info) : 32'h0);
      chk("data_bus",   32'(o_data_bus),   m_show ? 32'(m_data) : 32'h0);
    end
  end

  // ---------------------------------------------------------------- helpers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, output logic [N-1:0] g);
    g = '0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (o_msg_valid) begin
        g = o_grant;
        $display("issue   %s grant=%b no=%h info=%h data=%h dv=%b", name, o_grant, o_msg_no, o_msg_info, o_data_bus, o_data_valid);
        return;
      end
    end
    chk({name, "_valid_wait"}, 32'(0), 32'(1));
  endtask

  task automatic busy_pulse(input int delay, input int len);
    repeat (delay) tick();
    i_busy = 1'b1;
    repeat (len) tick();
    i_busy = 1'b0;
  endtask

  task automatic wait_done(input string name, output logic [N-1:0] d);
    d = '0;
    for (int k = 0; k < 200; k++) begin
      tick();
      if ((o_done | o_err) != '0) begin
        d = o_done;
        $display("finish  %s done=%b err=%b", name, o_done, o_err);
        return;
      end
    end
    chk({name, "_done_wait"}, 32'(0), 32'(1));
  endtask

  task automatic serve(input string name, output logic [N-1:0] g);
    logic [N-1:0] d;
    wait_valid(name, g);
    busy_pulse(2, 3);
    wait_done(name, d);
    chk({name, "_done_vec"}, 32'(d), 32'(g));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [N-1:0] g, d;
    logic [N-1:0] order [4];
    int n, saw;

    i_rst = 1'b1; i_flush = 1'b0; i_busy = 1'b0; i_req = 3'b111;
    i_msg_no = '0; i_msg_info = '0; i_data_bus = '0; i_data_valid = '0;

    // Reset held for 3 cycles with all requests high
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp_en = 1'b1;
      chk("rst_msg_valid", 32'(o_msg_valid), 32'(0));
      chk("rst_grant",     32'(o_grant),     32'(0));
      chk("rst_arb_busy",  32'(o_arb_busy),  32'(0));
    end
    $display("reset   done");
    i_req = '0;
    i_rst = 1'b0;

    // Single request from requester 1
    i_msg_no[7:4] = 4'h5; i_msg_info[5:3] = 3'h2; i_data_bus[31:16] = 16'hBEEF;
    i_data_valid[1] = 1'b1; i_req = 3'b010;
    wait_valid("single", g);
    chk("single_grant", 32'(o_grant),      32'(3'b010));
    chk("single_no",    32'(o_msg_no),     32'(4'h5));
    chk("single_info",  32'(o_msg_info),   32'(3'h2));
    chk("single_data",  32'(o_data_bus),   32'(16'hBEEF));
    chk("single_dv",    32'(o_data_valid), 32'(1));
    busy_pulse(2, 4);                       // busy over cycles T+2..T+5
    chk("single_grant_last", 32'(o_grant), 32'(3'b010));
    tick();                                 // T+7
    chk("single_done",  32'(o_done),  32'(3'b010));
    chk("single_grant_off", 32'(o_grant), 32'(0));
    i_req = '0;
    tick();
    chk("single_done_pulse", 32'(o_done), 32'(0));
    $display("single  done=%b checked", 3'b010);

    // Reset again so the pointer starts at 0
    i_rst = 1'b1; tick(); tick(); i_rst = 1'b0;

    // Round robin with all requests held
    i_msg_no = {4'h3, 4'h2, 4'h1}; i_msg_info = {3'h6, 3'h5, 3'h4};
    i_data_bus = {16'hC0C2, 16'hB0B1, 16'hA0A0}; i_data_valid = 3'b101;
    i_req = 3'b111;
    for (int k = 0; k < 4; k++) serve("rr", order[k]);
    i_req = '0;
    chk("rr_order0", 32'(order[0]), 32'(3'b001));
    chk("rr_order1", 32'(order[1]), 32'(3'b010));
    chk("rr_order2", 32'(order[2]), 32'(3'b100));
    chk("rr_order3", 32'(order[3]), 32'(3'b001));

    // Accept timeout for requester 2 (pointer now at 1)
    tick();
    i_req = 3'b100;
    wait_valid("timeout", g);
    chk("timeout_grant", 32'(g), 32'(3'b100));
    n = 0;
    for (int k = 0; k < 200; k++) begin
      tick();
      n++;
      if (o_err != '0) break;
    end
    $display("timeout err=%b after %0d cycles", o_err, n);
    chk("timeout_latency", 32'(n), 32'(ATO + 1));
    chk("timeout_err", 32'(o_err), 32'(3'b100));
    chk("timeout_no_done", 32'(o_done), 32'(0));
    i_req = 3'b101;                         // pointer wrapped to 0
    serve("after_timeout", g);
    chk("after_timeout_grant", 32'(g), 32'(3'b001));
    i_req = '0;

    // Flush while in WAIT_DONE, coincident with busy falling
    tick();
    i_req = 3'b001;
    wait_valid("flush", g);
    tick(); tick();
    i_busy = 1'b1;
    tick(); tick();
    i_flush = 1'b1; i_busy = 1'b0;
    tick();
    i_flush = 1'b0;
    chk("flush_grant",    32'(o_grant),    32'(0));
    chk("flush_arb_busy", 32'(o_arb_busy), 32'(0));
    chk("flush_done",     32'(o_done | o_err), 32'(0));
    chk("flush_msg_no",   32'(o_msg_no),   32'(0));
    $display("flush   grant=%b arb_busy=%b", o_grant, o_arb_busy);
    serve("reissue", g);
    chk("reissue_grant", 32'(g), 32'(3'b001));
    i_req = '0;

    // Withdrawn request: requester 1 pulses while requester 0 is served
    tick();
    saw = 0;
    i_req = 3'b001;
    wait_valid("withdraw", g);
    tick(); tick();
    i_busy = 1'b1;
    tick();
    i_req = 3'b011;
    tick();
    i_req = 3'b001;
    tick();
    i_busy = 1'b0;
    wait_done("withdraw", d);
    chk("withdraw_done", 32'(d), 32'(3'b001));
    i_req = '0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (o_grant[1]) saw++;
    end
    chk("withdraw_never_granted", 32'(saw), 32'(0));
    $display("withdraw grants_to_1=%0d", saw);

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sb_tx_msg_arbiter.md
# sb_tx_msg_arbiter

Round-robin arbiter and sequencer that shares the single sideband TX message path (SB_TX_WRAPPER message inputs) among NUM_REQ requesters (LTSM training FSM, adapter/RDI link-management, test-mode control). It captures one requester's message fields, issues a one-cycle message strobe to the SB TX path, and tracks the TX busy handshake. It reports completion or accept-timeout back to the granted requester, then rotates priority. It sits between the requesters and the SB_MB_WRAPPER message port.

## Interface
- NUM_REQ, 3, number of requesters (2..8)
- ACCEPT_TIMEOUT, 64, cycles to wait for i_busy to rise after issue before flagging error (≥2)

- i_clk  in  1  sideband clock
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  LTSM-in-reset abort; synchronous, highest priority after i_rst
- i_req  in  NUM_REQ  per-requester request level
- i_msg_no  in  4*NUM_REQ  message number, requester k at [4k+3:4k]
- i_msg_info  in  3*NUM_REQ  message info, [3k+2:3k]
- i_data_bus  in  16*NUM_REQ  message data, [16k+15:16k]
- i_data_valid  in  NUM_REQ  message carries data
- i_busy  in  1  SB TX path busy (from SB TX o_busy)
- o_msg_valid  out  1  one-cycle message strobe to SB TX
- o_msg_no  out  4  captured message number
- o_msg_info  out  3  captured message info
- o_data_bus  out  16  captured data
- o_data_valid  out  1  captured data-valid, asserted with o_msg_valid only
- o_grant  out  NUM_REQ  one-hot, held from ISSUE through end of WAIT_DONE
- o_done  out  NUM_REQ  one-cycle pulse: message sent
- o_err  out  NUM_REQ  one-cycle pulse: accept timeout
- o_arb_busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE: if any i_req, select first set bit searching upward from rr_ptr with wrap (index NUM_REQ-1 → 0). Capture that requester's msg_no/msg_info/data_bus/data_valid into holding registers, set grant index, go to ISSUE. No request: stay.
- ISSUE (1 cycle): o_msg_valid=1, o_data_valid=captured flag, o_grant one-hot. Clear timeout counter. Go to WAIT_BUSY.
- WAIT_BUSY: i_busy=1 → WAIT_DONE. Otherwise increment counter; when counter reaches ACCEPT_TIMEOUT-1 with i_busy still 0, pulse o_err[g], set rr_ptr=g+1 (mod NUM_REQ), go to IDLE.
- WAIT_DONE: i_busy=0 → pulse o_done[g], rr_ptr=g+1 (mod NUM_REQ), go to IDLE.
- o_msg_no/o_msg_info/o_data_bus hold captured values from ISSUE until the next capture. These outputs are 0 after reset/flush.
- Requesters must hold i_req and fields stable until o_done or o_err. Dropping i_req before selection is legal. Changes after capture are ignored.
- A requester whose i_req is still high in the IDLE cycle after its own done is eligible again, but loses to any other pending requester because of the rotated pointer.
- i_flush: next state IDLE, o_grant/o_msg_valid/o_data_valid cleared, counter cleared. No o_done/o_err pulse. rr_ptr and held fields unchanged.
- i_rst: all state/outputs to 0, rr_ptr=0, state IDLE.

## Timing
- Reset value of every output: 0.
- Request sampled in IDLE at cycle t → o_msg_valid and o_grant high at t+1. Minimum 1 idle cycle between messages (done pulse cycle is IDLE).
- o_grant high from ISSUE through the last WAIT_DONE cycle. Low in the o_done/o_err cycle.
- o_done/o_err registered: asserted the cycle after i_busy falls / timeout reached, coincident with state=IDLE. Exactly one cycle.
- i_busy already high during ISSUE is ignored. Only WAIT_BUSY samples the rise.
- Timeout: o_err asserted ACCEPT_TIMEOUT+1 cycles after o_msg_valid.
- Counter width: clog2(ACCEPT_TIMEOUT). Saturates, never wraps.
- i_flush and i_busy edge in the same cycle: i_flush wins, no pulse.

## Test plan
- Reset: i_rst high 3 cycles with i_req=3'b111 → all outputs 0, o_arb_busy 0, no o_msg_valid.
- Single request: i_req=3'b010, msg_no=4'h5, info=3'h2, data=16'hBEEF, dv=1; i_busy high 2 cycles after valid for 4 cycles → o_msg_valid 1 cycle with those fields, o_grant=3'b010, o_done=3'b010 one cycle after busy falls.
- Round-robin: i_req=3'b111 held continuously → grant order 0,1,2,0. No requester granted twice consecutively.
- Timeout (ACCEPT_TIMEOUT=64): i_req[2] with i_busy stuck 0 → o_err=3'b100 exactly 65 cycles after o_msg_valid. No o_done. Next grant goes to index 0.
- Flush mid-message: i_flush in WAIT_DONE with i_busy=1 → state IDLE next cycle, o_grant 0, no o_done/o_err. Pending request re-arbitrated after flush drops.
- Withdrawn request: i_req[1] pulsed 1 cycle while arbiter in WAIT_DONE for requester 0 → requester 1 never granted.
